// File: rtl/rf_wb_arbiter_pkg.sv
// Shared CPU definitions for the register-file write-port arbiter.
package cpu_pkg;
  localparam int REG_IDX_W    = 5;
  localparam int XLEN_DEFAULT = 32;
  localparam int NREG_DEFAULT = 32;
  localparam int STARVE_CNT_W = 4;

  typedef enum logic [0:0] {
    WB_PRI = 1'b0,
    MC_PRI = 1'b1
  } arb_state_t;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Request, grant, register-file and scoreboard signals of the write-port arbiter.
interface rf_wb_arbiter_if #(
  parameter int XLEN = cpu_pkg::XLEN_DEFAULT,
  parameter int NREG = cpu_pkg::NREG_DEFAULT
) ();
  logic                           wb_valid;
  logic [cpu_pkg::REG_IDX_W-1:0]  wb_rd;
  logic [XLEN-1:0]                wb_data;
  logic                           wb_ready;
  logic                           mc_valid;
  logic [cpu_pkg::REG_IDX_W-1:0]  mc_rd;
  logic [XLEN-1:0]                mc_data;
  logic                           mc_ready;
  logic                           iss_valid;
  logic [cpu_pkg::REG_IDX_W-1:0]  iss_rd;
  logic [cpu_pkg::REG_IDX_W-1:0]  rs1;
  logic [cpu_pkg::REG_IDX_W-1:0]  rs2;
  logic                           hazard;
  logic                           rf_we;
  logic [cpu_pkg::REG_IDX_W-1:0]  rf_rd;
  logic [XLEN-1:0]                rf_wdata;
  logic [NREG-1:0]                busy_vec;

  modport slave (
    input  wb_valid, wb_rd, wb_data, mc_valid, mc_rd, mc_data,
    input  iss_valid, iss_rd, rs1, rs2,
    output wb_ready, mc_ready, hazard, rf_we, rf_rd, rf_wdata, busy_vec
  );

  modport master (
    output wb_valid, wb_rd, wb_data, mc_valid, mc_rd, mc_data,
    output iss_valid, iss_rd, rs1, rs2,
    input  wb_ready, mc_ready, hazard, rf_we, rf_rd, rf_wdata, busy_vec
  );
endinterface

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Busy scoreboard of MC-pending destinations with decode RAW hazard compare.
module rf_scoreboard
  import cpu_pkg::*;
#(
  parameter int NREG = NREG_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_valid,
  input  logic [REG_IDX_W-1:0] set_rd,
  input  logic                 clr_valid,
  input  logic [REG_IDX_W-1:0] clr_rd,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  output logic [NREG-1:0]      busy_vec,
  output logic                 hazard
);
  logic [NREG-1:0] busy_q, busy_d;

  // Clear is applied before set so a same-cycle issue to the same index wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_valid) busy_d[clr_rd] = 1'b0;
    if (set_valid && set_rd != REG_ZERO) busy_d[set_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_vec = busy_q;
  assign hazard   = (rs1 != REG_ZERO && busy_q[rs1]) ||
                    (rs2 != REG_ZERO && busy_q[rs2]);
endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: WB priority with MC anti-starvation forcing.
// Optional statistics counters are enabled with the RF_ARB_STATS_EN macro.
module rf_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter int NREG         = NREG_DEFAULT,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  rf_wb_arbiter_if.slave   bus
`ifdef RF_ARB_STATS_EN
  ,
  output logic [15:0]      conflict_cnt,
  output logic [15:0]      forced_cnt
`endif
);
  localparam logic [STARVE_CNT_W-1:0] STARVE_LAST = STARVE_CNT_W'(STARVE_LIMIT - 1);

  arb_state_t              state_q;
  logic [STARVE_CNT_W-1:0] starve_q;
  logic                    mc_pri, conflict, grant_mc, grant_wb, enter_mc_pri;
  logic [REG_IDX_W-1:0]    rd_mux;
  logic [XLEN-1:0]         wdata_mux;

  always_comb begin
    mc_pri       = (state_q == MC_PRI);
    conflict     = bus.wb_valid && bus.mc_valid;
    grant_mc     = mc_pri ? bus.mc_valid : (bus.mc_valid && !bus.wb_valid);
    grant_wb     = bus.wb_valid && !grant_mc;
    enter_mc_pri = !mc_pri && conflict && (starve_q == STARVE_LAST);
  end

  // Zero-latency write mux so the write lands on this same edge.
  always_comb begin
    rd_mux    = REG_ZERO;
    wdata_mux = '0;
    if (grant_mc) begin
      rd_mux    = bus.mc_rd;
      wdata_mux = bus.mc_data;
    end else if (grant_wb) begin
      rd_mux    = bus.wb_rd;
      wdata_mux = bus.wb_data;
    end
  end

  assign bus.rf_we    = (grant_mc || grant_wb) && (rd_mux != REG_ZERO);
  assign bus.rf_rd    = rd_mux;
  assign bus.rf_wdata = wdata_mux;
  assign bus.wb_ready = !(mc_pri && bus.mc_valid);
  assign bus.mc_ready = grant_mc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= WB_PRI;
      starve_q <= '0;
    end else begin
      case (state_q)
        WB_PRI: begin
          if (conflict) begin
            starve_q <= starve_q + 1'b1;
            if (enter_mc_pri) state_q <= MC_PRI;
          end else begin
            starve_q <= '0;
          end
        end
        MC_PRI: begin
          state_q  <= WB_PRI;
          starve_q <= '0;
        end
        default: begin
          state_q  <= WB_PRI;
          starve_q <= '0;
        end
      endcase
    end
  end

  rf_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_valid (bus.iss_valid),
    .set_rd    (bus.iss_rd),
    .clr_valid (bus.mc_valid && grant_mc),
    .clr_rd    (bus.mc_rd),
    .rs1       (bus.rs1),
    .rs2       (bus.rs2),
    .busy_vec  (bus.busy_vec),
    .hazard    (bus.hazard)
  );

`ifdef RF_ARB_STATS_EN
  logic [15:0] conflict_q, forced_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_q <= '0;
      forced_q   <= '0;
    end else begin
      if (conflict && conflict_q != 16'hFFFF)   conflict_q <= conflict_q + 16'd1;
      if (enter_mc_pri && forced_q != 16'hFFFF) forced_q   <= forced_q + 16'd1;
    end
  end

  assign conflict_cnt = conflict_q;
  assign forced_cnt   = forced_q;
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard-driven bench for the register-file write-port arbiter.
module tb_rf_wb_arbiter;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_wb_arbiter_if #(.XLEN(32), .NREG(32)) bus ();
`ifdef RF_ARB_STATS_EN
  logic [15:0] conflict_cnt, forced_cnt;
`endif

  rf_wb_arbiter #(.XLEN(32), .NREG(32), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef RF_ARB_STATS_EN
    ,
    .conflict_cnt (conflict_cnt),
    .forced_cnt   (forced_cnt)
`endif
  );

  typedef struct {
    logic wv; logic [4:0] wrd; logic [31:0] wd;
    logic mv; logic [4:0] mrd; logic [31:0] md;
    logic iv; logic [4:0] ird; logic [4:0] r1; logic [4:0] r2;
  } stim_t;

  typedef struct { string name; logic [72:0] v; } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic stim_t S(logic wv, logic [4:0] wrd, logic [31:0] wd,
                              logic mv, logic [4:0] mrd, logic [31:0] md,
                              logic iv, logic [4:0] ird, logic [4:0] r1, logic [4:0] r2);
    stim_t s;
    s = '{wv, wrd, wd, mv, mrd, md, iv, ird, r1, r2};
    return s;
  endfunction

  // Expected vector: {rf_we, rf_rd, rf_wdata, wb_ready, mc_ready, hazard, busy_vec}
  function automatic logic [72:0] mk(logic we, logic [4:0] rd, logic [31:0] d,
                                     logic wbr, logic mcr, logic hz, logic [31:0] busy);
    return {we, rd, d, wbr, mcr, hz, busy};
  endfunction

  function automatic logic [72:0] obs();
    return {bus.rf_we, bus.rf_rd, bus.rf_wdata, bus.wb_ready, bus.mc_ready,
            bus.hazard, bus.busy_vec};
  endfunction

  task automatic apply(input stim_t s);
    bus.wb_valid  = s.wv;  bus.wb_rd  = s.wrd; bus.wb_data = s.wd;
    bus.mc_valid  = s.mv;  bus.mc_rd  = s.mrd; bus.mc_data = s.md;
    bus.iss_valid = s.iv;  bus.iss_rd = s.ird;
    bus.rs1       = s.r1;  bus.rs2    = s.r2;
  endtask

  localparam logic [72:0] IDLE_EXP = {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0};

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    apply(S(0,0,0, 0,0,0, 0,0,0,0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back('{"reset_state", IDLE_EXP});
    #2;
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e.v) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", e.name, obs(), e.v);
    end
`ifdef RF_ARB_STATS_EN
    checks++;
    if (conflict_cnt !== 16'd0 || forced_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_stats: got=%h/%h expected=0/0", conflict_cnt, forced_cnt);
    end
`endif
  endtask

  task automatic test_wb_only();
    stim_t st[$];
    exp_t  e;
    st.push_back(S(1,5,32'hDEAD_BEEF, 0,0,0, 0,0,0,0));
    st.push_back(S(1,31,32'h0000_0001, 0,0,0, 0,0,0,0));
    st.push_back(S(1,0,32'h5555_AAAA, 0,0,0, 0,0,0,0));
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk);
      apply(st[i]);
      exp_q.push_back('{$sformatf("wb_only_%0d", i),
                        mk(st[i].wrd != 0, st[i].wrd, st[i].wd, 1'b1, 1'b0, 1'b0, 32'd0)});
      #2;
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e.v) begin
        errors++;
        $display("FAIL %s: got=%h expected=%h", e.name, obs(), e.v);
      end
    end
  endtask

  task automatic test_starvation();
    exp_t e;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c <= 6) apply(S(1,2,32'hA5A5_0001, 1,7,32'h0000_7777, 0,0,0,0));
      else        apply(S(0,0,0, 0,0,0, 0,0,0,0));
      if (c == 5)      exp_q.push_back('{$sformatf("starve_c%0d", c),
                                        mk(1,7,32'h0000_7777,0,1,0,32'd0)});
      else if (c == 7) exp_q.push_back('{"starve_idle", IDLE_EXP});
      else             exp_q.push_back('{$sformatf("starve_c%0d", c),
                                        mk(1,2,32'hA5A5_0001,1,0,0,32'd0)});
      #2;
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e.v) begin
        errors++;
        $display("FAIL %s: got=%h expected=%h", e.name, obs(), e.v);
      end
    end
`ifdef RF_ARB_STATS_EN
    checks++;
    if (conflict_cnt !== 16'd6 || forced_cnt !== 16'd1) begin
      errors++;
      $display("FAIL starve_stats: got=%0d/%0d expected=6/1", conflict_cnt, forced_cnt);
    end
`endif
  endtask

  task automatic test_x0();
    stim_t st[$];
    logic [72:0] ex[$];
    exp_t e;
    st.push_back(S(0,0,0, 1,0,32'h0000_1234, 0,0,0,0));
    ex.push_back(mk(0,0,32'h0000_1234,1,1,0,32'd0));
    st.push_back(S(0,0,0, 1,12,32'h0000_CAFE, 0,0,0,0));
    ex.push_back(mk(1,12,32'h0000_CAFE,1,1,0,32'd0));
    st.push_back(S(0,0,0, 0,0,0, 0,0,0,0));
    ex.push_back(IDLE_EXP);
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk);
      apply(st[i]);
      exp_q.push_back('{$sformatf("x0_mc_%0d", i), ex[i]});
      #2;
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e.v) begin
        errors++;
        $display("FAIL %s: got=%h expected=%h", e.name, obs(), e.v);
      end
    end
  endtask

  task automatic test_scoreboard();
    stim_t st[$];
    logic [72:0] ex[$];
    exp_t e;
    st.push_back(S(0,0,0, 0,0,0, 1,9,0,0));           ex.push_back(IDLE_EXP);
    st.push_back(S(0,0,0, 0,0,0, 0,0,9,0));           ex.push_back(mk(0,0,0,1,0,1,32'h200));
    st.push_back(S(0,0,0, 0,0,0, 0,0,0,9));           ex.push_back(mk(0,0,0,1,0,1,32'h200));
    st.push_back(S(0,0,0, 1,9,32'h99, 0,0,9,0));      ex.push_back(mk(1,9,32'h99,1,1,1,32'h200));
    st.push_back(S(0,0,0, 0,0,0, 0,0,9,9));           ex.push_back(IDLE_EXP);
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk);
      apply(st[i]);
      exp_q.push_back('{$sformatf("scoreboard_%0d", i), ex[i]});
      #2;
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e.v) begin
        errors++;
        $display("FAIL %s: got=%h expected=%h", e.name, obs(), e.v);
      end
    end
  endtask

  task automatic test_set_clear();
    stim_t st[$];
    logic [72:0] ex[$];
    exp_t e;
    st.push_back(S(0,0,0, 0,0,0, 1,3,0,0));           ex.push_back(IDLE_EXP);
    st.push_back(S(0,0,0, 1,3,32'h33, 1,3,0,0));      ex.push_back(mk(1,3,32'h33,1,1,0,32'h8));
    st.push_back(S(0,0,0, 0,0,0, 0,0,0,0));           ex.push_back(mk(0,0,0,1,0,0,32'h8));
    st.push_back(S(0,0,0, 1,3,32'h33, 0,0,0,0));      ex.push_back(mk(1,3,32'h33,1,1,0,32'h8));
    st.push_back(S(1,3,32'h44, 0,0,0, 0,0,3,0));      ex.push_back(mk(1,3,32'h44,1,0,0,32'h0));
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk);
      apply(st[i]);
      exp_q.push_back('{$sformatf("set_clear_%0d", i), ex[i]});
      #2;
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e.v) begin
        errors++;
        $display("FAIL %s: got=%h expected=%h", e.name, obs(), e.v);
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t st[$];
    logic [72:0] ex[$];
    exp_t e;
    st.push_back(S(0,0,0, 0,0,0, 1,4,0,0));           ex.push_back(IDLE_EXP);
    st.push_back(S(0,0,0, 0,0,0, 1,6,0,0));           ex.push_back(mk(0,0,0,1,0,0,32'h10));
    for (int c = 0; c < 4; c++) begin
      st.push_back(S(1,1,32'h11, 1,8,32'h88, 0,0,4,0));
      ex.push_back(mk(1,1,32'h11,1,0,1,32'h50));
    end
    st.push_back(S(1,1,32'h11, 1,8,32'h88, 0,0,4,0)); ex.push_back(mk(1,8,32'h88,0,1,1,32'h50));
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk);
      apply(st[i]);
      exp_q.push_back('{$sformatf("pre_rst_%0d", i), ex[i]});
      #2;
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e.v) begin
        errors++;
        $display("FAIL %s: got=%h expected=%h", e.name, obs(), e.v);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    apply(S(0,0,0, 0,0,0, 0,0,4,6));
    exp_q.push_back('{"mid_reset_state", IDLE_EXP});
    #2;
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e.v) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", e.name, obs(), e.v);
    end
`ifdef RF_ARB_STATS_EN
    checks++;
    if (conflict_cnt !== 16'd0 || forced_cnt !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset_stats: got=%h/%h expected=0/0", conflict_cnt, forced_cnt);
    end
`endif
    // A cleared starve counter means the full four blocked cycles are needed again.
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c <= 5) apply(S(1,1,32'h11, 1,8,32'h88, 0,0,0,0));
      else        apply(S(0,0,0, 0,0,0, 0,0,0,0));
      if (c == 5)      exp_q.push_back('{"post_rst_force", mk(1,8,32'h88,0,1,0,32'd0)});
      else if (c == 6) exp_q.push_back('{"post_rst_idle", IDLE_EXP});
      else             exp_q.push_back('{$sformatf("post_rst_wb_%0d", c),
                                        mk(1,1,32'h11,1,0,0,32'd0)});
      #2;
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e.v) begin
        errors++;
        $display("FAIL %s: got=%h expected=%h", e.name, obs(), e.v);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_wb_only();
    test_starvation();
    test_x0();
    test_scoreboard();
    test_set_clear();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Controls the single register-file write port in the pipelined CPU.
- Shares the port between two requesters: the in-order pipeline writeback (WB) and a multi-cycle unit (MC, e.g. mul/div/load) using valid/ready.
- WB normally has priority. An anti-starvation counter periodically forces an MC grant.
- Holds a 32-entry busy scoreboard of MC-pending destinations so decode can stall on RAW hazards.

Parameters:
- XLEN, 32, data width of register-file writes
- NREG, 32, number of architectural registers (index width = $clog2(NREG))
- STARVE_LIMIT, 4, consecutive cycles an MC request may be blocked before MC priority is forced (range 1..15)

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- wb_valid  in  1  pipeline writeback request
- wb_rd  in  5  WB destination register
- wb_data  in  XLEN  WB write data
- wb_ready  out  1  WB accepted this cycle; low means the pipeline must freeze and hold WB inputs
- mc_valid  in  1  MC result request
- mc_rd  in  5  MC destination register
- mc_data  in  XLEN  MC write data
- mc_ready  out  1  MC result accepted this cycle
- iss_valid  in  1  MC op issued from decode this cycle
- iss_rd  in  5  destination of the issued MC op
- rs1  in  5  decode source 1 for hazard check
- rs2  in  5  decode source 2 for hazard check
- hazard  out  1  rs1 or rs2 is busy in the scoreboard
- rf_we  out  1  register-file write enable
- rf_rd  out  5  register-file write index
- rf_wdata  out  XLEN  register-file write data
- busy_vec  out  NREG  scoreboard bits (bit 0 always 0)

Behaviour:
- Reset (rst high at posedge):
  - state=WB_PRI, starve_cnt=0, busy_vec=0.
  - Outputs follow combinationally from the reset state: rf_we=0 with no requests, wb_ready=1, mc_ready=0.
- Latency: grant, rf_we, rf_rd and rf_wdata are combinational from the current inputs and registered state. This is zero-cycle, so the write lands at the same posedge and the register file's same-cycle read bypass still works.
- FSM states: WB_PRI, MC_PRI.
  - WB_PRI:
    - wb_valid → grant WB.
    - Else mc_valid → grant MC.
    - If mc_valid && wb_valid: starve_cnt++.
    - When starve_cnt reaches STARVE_LIMIT-1 with MC still blocked, go to MC_PRI next cycle.
  - MC_PRI:
    - mc_valid → grant MC and drive wb_ready=0 (even if wb_valid).
    - Return to WB_PRI next cycle and clear starve_cnt.
    - If mc_valid dropped, grant WB normally and return to WB_PRI.
- starve_cnt is cleared on any MC grant, and whenever mc_valid=0.
- Handshake:
  - wb_ready = !(state==MC_PRI && mc_valid).
  - mc_ready = grant_mc.
  - A transfer completes when valid && ready. Ungranted sources must hold their inputs stable.
- x0 rule: a granted request with rd==0 completes its handshake but forces rf_we=0.
- rf_rd and rf_wdata come from the granted source, and are 0 when there is no grant.
- Scoreboard:
  - iss_valid && iss_rd!=0 sets busy[iss_rd].
  - A completed MC transfer clears busy[mc_rd].
  - Set and clear of the same index in one cycle: set wins.
  - A WB write never touches busy.
- hazard = (rs1!=0 && busy[rs1]) || (rs2!=0 && busy[rs2]). Combinational; it does not reflect same-cycle set or clear.
- rst mid-operation: all pending busy bits are dropped. The pipeline is flushed externally.

Optional Feature:
- RF_ARB_STATS_EN.
- Defined:
  - Adds output conflict_cnt[15:0]. It counts cycles with wb_valid && mc_valid, saturates at 16'hFFFF, and resets to 0.
  - Adds output forced_cnt[15:0]. It counts MC_PRI entries, saturates at 16'hFFFF, and resets to 0.
- Undefined: neither port nor any counter logic exists. Arbitration behaviour is identical in both builds.

Decomposition:
- Shared package cpu_pkg holds:
  - REG_IDX_W=5, XLEN default, NREG.
  - Typedef arb_state_t {WB_PRI, MC_PRI}.
  - Constant REG_ZERO=5'd0.
- One natural sub-module, rf_scoreboard: busy_vec storage, set/clear priority and the hazard compare. The arbiter FSM, starve counter and write mux stay in the top.

Test Plan:
- Reset, then WB only:
  - Stimulus: wb_valid=1, wb_rd=5, wb_data=32'hDEAD_BEEF.
  - Response: rf_we=1, rf_rd=5, rf_wdata=32'hDEADBEEF, wb_ready=1, mc_ready=0.
- Starvation, STARVE_LIMIT=4:
  - Stimulus: wb_valid and mc_valid both held high, mc_rd=7.
  - Response: MC blocked for cycles 1-4. Cycle 5: mc_ready=1, wb_ready=0, rf_rd=7. Cycle 6: WB granted again.
- x0 write:
  - Stimulus: mc_valid=1, mc_rd=0, mc_data=32'h1234, wb_valid=0.
  - Response: mc_ready=1, rf_we=0, busy_vec unchanged.
- Scoreboard:
  - Stimulus: iss_valid with iss_rd=9; next cycle rs1=9; then MC completes to rd=9.
  - Response: busy_vec[9]=1 and hazard=1. After completion busy_vec[9]=0 and hazard=0 the following cycle.
- Simultaneous set and clear:
  - Stimulus: MC completes rd=3 while iss_rd=3 in the same cycle.
  - Response: busy_vec[3]=1.
- Reset mid-operation:
  - Stimulus: busy bits 4 and 6 set, state=MC_PRI, then rst=1 for one cycle.
  - Response: busy_vec=0, state=WB_PRI, starve_cnt=0. With the stats build, both counters read 0.
